// File: rtl/k580vt57_pkg.sv
// Shared types, register map and mode bit positions for the K580VT57 (i8257
// compatible) four-channel DMA controller.
package k580vt57_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } state_t;

  // Transfer type lives in count[15:14]
  typedef enum logic [1:0] {
    XF_VERIFY  = 2'b00,
    XF_WRITE   = 2'b01,
    XF_READ    = 2'b10,
    XF_ILLEGAL = 2'b11
  } xfer_t;

  localparam int MODE_ROTATE   = 4;
  localparam int MODE_EXTWR    = 5;
  localparam int MODE_TCSTOP   = 6;
  localparam int MODE_AUTOLOAD = 7;

  localparam logic [3:0] REG_MODE   = 4'd8;
  localparam int         CNT_MSB    = 13;
  localparam logic [1:0] AUTO_SRC   = 2'd3;
  localparam logic [1:0] AUTO_DST   = 2'd2;

  // Replace one byte of a 16-bit register, as selected by the first/last flip-flop.
  function automatic logic [15:0] set_byte(input logic [15:0] word, input logic hi,
                                           input logic [7:0] b);
    return hi ? {b, word[7:0]} : {word[15:8], b};
  endfunction

endpackage

// File: rtl/k580vt57_prio.sv
// Combinational 4-way priority encoder; channel 'base' has the highest
// priority and priority falls with increasing channel number, modulo 4.
module k580vt57_prio
  import k580vt57_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        base,
  output logic [1:0]        win,
  output logic              valid
);

  logic [NUM_CH-1:0] rot;
  logic [1:0]        off;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rot[gi] = req[2'(gi) + base];
    end
  endgenerate

  always_comb begin
    off = 2'd0;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign win   = off + base;
  assign valid = |req;

endmodule

// File: rtl/k580vt57_dma.sv
// Four-channel DMA controller, register compatible with the K580VT57 / i8257:
// CPU register file, bus hold handshake and the S0..S4 transfer sequencer.
module k580vt57_dma
  import k580vt57_pkg::*;
#(
  parameter int CH_NUM = NUM_CH
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_dma,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        aen,
  output logic        omemr_n,
  output logic        omemw_n,
  output logic        oior_n,
  output logic        oiow_n,
  output logic        tc
);

  logic [15:0] addr_reg [CH_NUM];
  logic [15:0] cnt_reg  [CH_NUM];
  logic [7:0]  mode_reg;
  logic [3:0]  tcflag_reg;
  logic        update_reg;
  logic        ff_reg;
  state_t      state_reg;
  logic [1:0]  ch_reg;
  logic [1:0]  last_reg;
  xfer_t       xfer_reg;
  logic        iwe_n_reg;
  logic        ird_n_reg;

  logic        wr_stb;
  logic        rd_done;
  logic        is_chreg;
  logic        is_mode;
  logic [1:0]  sel_ch;
  logic [3:0]  req;
  logic [1:0]  prio_base;
  logic [1:0]  prio_win;
  logic        prio_valid;
  logic        go_s1;
  logic [15:0] rd_word;

  assign wr_stb    = iwe_n_reg & ~iwe_n;
  assign rd_done   = ~ird_n_reg & ird_n;
  assign is_chreg  = ~iaddr[3];
  assign is_mode   = (iaddr == REG_MODE);
  assign sel_ch    = iaddr[2:1];
  assign req       = drq & mode_reg[3:0];
  // Rotating mode: the channel after the last one serviced is checked first
  assign prio_base = mode_reg[MODE_ROTATE] ? last_reg + 2'd1 : 2'd0;
  assign go_s1     = (state_reg == ST_S0 || state_reg == ST_S4) && hlda && prio_valid;

  k580vt57_prio u_prio (
    .req   (req),
    .base  (prio_base),
    .win   (prio_win),
    .valid (prio_valid)
  );

  always_comb begin
    rd_word = iaddr[0] ? cnt_reg[sel_ch] : addr_reg[sel_ch];
    odata   = 8'h00;
    if (is_chreg)
      odata = ff_reg ? rd_word[15:8] : rd_word[7:0];
    else if (is_mode)
      odata = {3'b000, update_reg, tcflag_reg};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        addr_reg[i] <= 16'h0000;
        cnt_reg[i]  <= 16'h0000;
      end
      mode_reg   <= 8'h00;
      tcflag_reg <= 4'h0;
      update_reg <= 1'b0;
      ff_reg     <= 1'b0;
      state_reg  <= ST_IDLE;
      ch_reg     <= 2'd0;
      last_reg   <= 2'd3;
      xfer_reg   <= XF_VERIFY;
      iwe_n_reg  <= 1'b1;
      ird_n_reg  <= 1'b1;
      hrq        <= 1'b0;
      aen        <= 1'b0;
      tc         <= 1'b0;
      dack       <= 4'h0;
      oaddr      <= 16'h0000;
      omemr_n    <= 1'b1;
      omemw_n    <= 1'b1;
      oior_n     <= 1'b1;
      oiow_n     <= 1'b1;
    end else begin
      iwe_n_reg <= iwe_n;
      ird_n_reg <= ird_n;

      // CPU side first so that a same-tick sequencer update overrides it
      if (wr_stb) begin
        if (is_chreg) begin
          ff_reg <= ~ff_reg;
          if (iaddr[0]) begin
            cnt_reg[sel_ch] <= set_byte(cnt_reg[sel_ch], ff_reg, idata);
            if (mode_reg[MODE_AUTOLOAD] && sel_ch == AUTO_DST)
              cnt_reg[AUTO_SRC] <= set_byte(cnt_reg[AUTO_SRC], ff_reg, idata);
          end else begin
            addr_reg[sel_ch] <= set_byte(addr_reg[sel_ch], ff_reg, idata);
            if (mode_reg[MODE_AUTOLOAD] && sel_ch == AUTO_DST)
              addr_reg[AUTO_SRC] <= set_byte(addr_reg[AUTO_SRC], ff_reg, idata);
          end
        end else if (is_mode) begin
          mode_reg <= idata;
          ff_reg   <= 1'b0;
        end
      end
      if (rd_done) begin
        if (is_chreg)
          ff_reg <= ~ff_reg;
        else if (is_mode)
          tcflag_reg <= 4'h0;
      end

      if (ce_dma) begin
        case (state_reg)
          ST_IDLE: begin
            if (|req) begin
              hrq       <= 1'b1;
              state_reg <= ST_S0;
            end
          end
          ST_S0: begin
            if (!(|req)) begin
              hrq       <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
          ST_S1: begin
            state_reg <= ST_S2;
            if (xfer_reg == XF_READ) begin
              omemr_n <= 1'b0;
              if (mode_reg[MODE_EXTWR]) oiow_n <= 1'b0;
            end else if (xfer_reg == XF_WRITE) begin
              oior_n <= 1'b0;
              if (mode_reg[MODE_EXTWR]) omemw_n <= 1'b0;
            end
          end
          ST_S2: begin
            state_reg <= ST_S3;
            tc        <= (cnt_reg[ch_reg][CNT_MSB:0] == 14'd0);
            if (xfer_reg == XF_READ)
              oiow_n <= 1'b0;
            else if (xfer_reg == XF_WRITE)
              omemw_n <= 1'b0;
          end
          ST_S3: begin
            state_reg        <= ST_S4;
            omemr_n          <= 1'b1;
            omemw_n          <= 1'b1;
            oior_n           <= 1'b1;
            oiow_n           <= 1'b1;
            tc               <= 1'b0;
            addr_reg[ch_reg] <= addr_reg[ch_reg] + 16'd1;
            cnt_reg[ch_reg]  <= {cnt_reg[ch_reg][15:14], cnt_reg[ch_reg][CNT_MSB:0] - 14'd1};
            if (tc) begin
              tcflag_reg[ch_reg] <= 1'b1;
              if (mode_reg[MODE_TCSTOP])
                mode_reg[ch_reg] <= 1'b0;
              if (mode_reg[MODE_AUTOLOAD] && ch_reg == AUTO_DST) begin
                addr_reg[AUTO_DST] <= addr_reg[AUTO_SRC];
                cnt_reg[AUTO_DST]  <= cnt_reg[AUTO_SRC];
                update_reg         <= 1'b1;
              end
            end
          end
          ST_S4: begin
            if (!go_s1) begin
              hrq       <= 1'b0;
              aen       <= 1'b0;
              dack      <= 4'h0;
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase

        // Grant: latch the winner and put its address on the bus for S1
        if (go_s1) begin
          state_reg <= ST_S1;
          ch_reg    <= prio_win;
          last_reg  <= prio_win;
          xfer_reg  <= xfer_t'(cnt_reg[prio_win][15:14]);
          oaddr     <= addr_reg[prio_win];
          aen       <= 1'b1;
          dack      <= 4'b0001 << prio_win;
          if (prio_win == AUTO_DST)
            update_reg <= 1'b0;
        end
      end
    end
  end

endmodule
